nibble_serial_adder: RTL and testbench
======================================

# nibble_serial_adder

Multi-cycle controller that adds WIDTH-bit operands through a single shared 4-bit ripple-carry adder, one nibble per clock, least-significant nibble first. The inter-nibble carry is held in a register between cycles. It sits between an operand producer and a result consumer, with a valid/ready handshake on each side. Wide additions cost one 4-bit adder plus sequencing logic, at the price of WIDTH/4 cycles per operation.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of 4 and at least 8
- clk  input  1  rising-edge clock
- rst  input  1  reset; asynchronous, active-high
- in_valid  input  1  operands present
- in_ready  output  1  block can accept operands
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in to nibble 0
- sub  input  1  subtract (A − B); port exists only with NSA_SUB_EN
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  result
- cout  output  1  carry out of the most significant nibble
- busy  output  1  high in RUN or DONE

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch a and b into shift registers, load carry_reg with the effective carry-in, clear the nibble counter, go to RUN.
- RUN, each cycle:
  - The adder takes a_reg[3:0], b_reg[3:0] (inverted when subtracting) and carry_reg.
  - The 4-bit adder sum shifts into sum_reg from the MSB end. a_reg and b_reg shift right by 4.
  - carry_reg takes the adder's carry out. The counter increments.
  - After NIBBLES=WIDTH/4 RUN cycles, go to DONE.
- DONE:
  - out_valid=1. sum and cout are held stable.
  - On out_valid&&out_ready: go to IDLE.
- Input and output handshakes never overlap: in_ready=0 outside IDLE.
- Input changes while in RUN or DONE are ignored.
- Arithmetic is modulo 2^WIDTH. cout is the final carry_reg value; no separate overflow flag.
- sum and cout are only meaningful while out_valid=1. Outside DONE they show the current register contents.
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, sum=0, cout=0, counter=0, carry_reg=0.
- Reset asserted mid-operation: the operation is discarded with no output. in_ready=1 from the first edge after rst deasserts.

## Timing
- Operand acceptance on edge k.
- RUN occupies edges k+1..k+NIBBLES.
- out_valid rises after edge k+NIBBLES: latency NIBBLES cycles, i.e. 4 for WIDTH=16.
- The result handshake on edge m returns the block to IDLE after edge m. in_ready=1 in the next cycle.
- Minimum period between acceptances: NIBBLES+2 cycles when out_ready is held high.
- No combinational path from inputs to outputs; all outputs are registered or decoded from state.

## Configuration
- NSA_SUB_EN defined:
  - sub port present and latched on acceptance.
  - With sub=1: B nibbles are inverted, the initial carry is forced to 1, and cin is ignored. cout=1 means no borrow.
  - With sub=0: normal addition using cin.
- NSA_SUB_EN undefined: no sub port; the block always adds with cin.

## Structure
- Package nibble_serial_pkg:
  - NIBBLE_W=4
  - FSM state enum (IDLE, RUN, DONE)
  - helper function for NIBBLES from WIDTH
- Sub-module nibble_adder: 4-bit ripple-carry adder built from full-adder cells; ports a[3:0], b[3:0], cin, s[3:0], cout. Instantiated exactly once.

## Test plan
- Basic add: reset, then a=0x1234, b=0x4321, cin=0 → sum=0x5555, cout=0. out_valid exactly 4 cycles after acceptance; in_ready=0 throughout.
- Full-width carry ripple: 0xFFFF+0x0001, cin=0 → sum=0x0000, cout=1. Also 0x7FFF+0x0000, cin=1 → sum=0x8000, cout=0.
- Backpressure: out_ready low for 3 cycles in DONE → sum and out_valid held stable, in_ready=0. After out_ready=1, in_ready=1 one cycle later. A new in_valid during DONE is not accepted.
- Reset mid-RUN: assert rst after 2 RUN cycles → all outputs return to reset values immediately. No out_valid after release. The next operation 0x0001+0x0002 → 0x0003.
- Subtract (NSA_SUB_EN): 0x1000−0x0001 → 0x0FFF, cout=1. 0x0000−0x0001 → 0xFFFF, cout=0. cin=1 is ignored in both cases.
- Back-to-back: 8 random operand pairs with out_ready tied high → each result matches a reference model, with acceptances spaced exactly 6 cycles apart.

Source files
------------

// File: rtl/nibble_serial_pkg.sv
// Shared types and constants for the nibble-serial adder.
// Holds the nibble width, the FSM state encoding and the nibble-count helper.
package nibble_serial_pkg;

   localparam int NIBBLE_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   function automatic int nibbles(input int width);
      return width / NIBBLE_W;
   endfunction

endpackage

// File: rtl/nibble_serial_if.sv
// Operand/result handshake bundle for nibble_serial_adder.
// The sub signal exists only when NSA_SUB_EN is defined.
interface nibble_serial_if #(parameter int WIDTH = 16);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
`ifdef NSA_SUB_EN
   logic             sub;
`endif
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             busy;

   modport master (
`ifdef NSA_SUB_EN
      output sub,
`endif
      output in_valid, a, b, cin, out_ready,
      input  in_ready, out_valid, sum, cout, busy
   );

   modport slave (
`ifdef NSA_SUB_EN
      input  sub,
`endif
      input  in_valid, a, b, cin, out_ready,
      output in_ready, out_valid, sum, cout, busy
   );

endinterface

// File: rtl/nibble_adder.sv
// 4-bit ripple-carry adder built from full-adder cells.
module nibble_adder
   import nibble_serial_pkg::*;
(
   input  logic [NIBBLE_W-1:0] a,
   input  logic [NIBBLE_W-1:0] b,
   input  logic                cin,
   output logic [NIBBLE_W-1:0] s,
   output logic                cout
);

   logic [NIBBLE_W:0] c;

   assign c[0] = cin;

   for (genvar i = 0; i < NIBBLE_W; i++) begin : g_fa
      assign s[i]   = a[i] ^ b[i] ^ c[i];
      assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
   end

   assign cout = c[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// Adds WIDTH-bit operands one nibble per clock through a single shared 4-bit adder.
// Define NSA_SUB_EN to add the sub input (A - B via inverted B and forced carry-in).
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// RUN   | one nibble added per cycle, LS nibble first
// DONE  | result held on sum/cout until the consumer takes it
module nibble_serial_adder
   import nibble_serial_pkg::*;
#(
   parameter int WIDTH = 16
)
(
   input  logic           clk,
   input  logic           rst,
   nibble_serial_if.slave bus
);

   localparam int NIB   = nibbles(WIDTH);
   localparam int CNT_W = $clog2(NIB + 1);

   state_e               state_q;
   logic [WIDTH-1:0]     a_q;
   logic [WIDTH-1:0]     b_q;
   logic [WIDTH-1:0]     sum_q;
   logic [WIDTH-1:0]     sum_d;
   logic                 carry_q;
   logic [CNT_W-1:0]     cnt_q;
   logic                 in_ready_q;
   logic                 out_valid_q;
   logic                 busy_q;
   logic                 sub_q;
   logic [NIBBLE_W-1:0]  add_b;
   logic [NIBBLE_W-1:0]  add_s;
   logic                 add_co;

`ifndef NSA_SUB_EN
   assign sub_q = 1'b0;
`endif

   assign add_b = b_q[NIBBLE_W-1:0] ^ {NIBBLE_W{sub_q}};
   // New nibble enters at the top, so after NIB shifts nibble 0 sits at the bottom.
   assign sum_d = {add_s, sum_q[WIDTH-1:NIBBLE_W]};

   nibble_adder u_adder (
      .a    (a_q[NIBBLE_W-1:0]),
      .b    (add_b),
      .cin  (carry_q),
      .s    (add_s),
      .cout (add_co)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         sum_q       <= '0;
         carry_q     <= 1'b0;
         cnt_q       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
`ifdef NSA_SUB_EN
         sub_q       <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.in_valid && in_ready_q) begin
                  a_q        <= bus.a;
                  b_q        <= bus.b;
                  cnt_q      <= '0;
`ifdef NSA_SUB_EN
                  sub_q      <= bus.sub;
                  carry_q    <= bus.sub ? 1'b1 : bus.cin;
`else
                  carry_q    <= bus.cin;
`endif
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
                  state_q    <= RUN;
               end
            end
            RUN: begin
               sum_q   <= sum_d;
               a_q     <= a_q >> NIBBLE_W;
               b_q     <= b_q >> NIBBLE_W;
               carry_q <= add_co;
               cnt_q   <= cnt_q + 1'b1;
               if (cnt_q == CNT_W'(NIB - 1)) begin
                  out_valid_q <= 1'b1;
                  state_q     <= DONE;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= IDLE;
               end
            end
            default: begin
               out_valid_q <= 1'b0;
               busy_q      <= 1'b0;
               in_ready_q  <= 1'b1;
               state_q     <= IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.busy      = busy_q;
   assign bus.sum       = sum_q;
   assign bus.cout      = carry_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder: directed vector table,
// backpressure and mid-run reset sequences, and random back-to-back operations.
module tb_nibble_serial_adder;

   localparam int WIDTH = 16;
   localparam int NIB   = WIDTH / 4;

   typedef struct {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic             cin;
      logic             sub;
      logic [WIDTH-1:0] exp_sum;
      logic             exp_cout;
      string            name;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   nibble_serial_if #(.WIDTH(WIDTH)) bus ();

   nibble_serial_adder #(.WIDTH(WIDTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Reference: whole-word arithmetic, no nibble sequencing.
   function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                            input logic ci, input logic sb);
      logic [WIDTH:0] r;
      if (sb) r = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
      else    r = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(ci);
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic accept(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic ci, input logic sb, output int acc_cyc);
      int n;
      n = 0;
      bus.a   = a;
      bus.b   = b;
      bus.cin = ci;
`ifdef NSA_SUB_EN
      bus.sub = sb;
`endif
      bus.in_valid = 1'b1;
      while (bus.in_ready !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      if (n >= 20) chk("accept_wait", 64'(n), 64'(0));
      tick();
      acc_cyc = cyc;
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_result(output int lat);
      int bad_ready;
      lat = 0;
      bad_ready = 0;
      while (bus.out_valid !== 1'b1 && lat < 40) begin
         if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) bad_ready++;
         tick();
         lat++;
      end
      chk("ready_low_in_run", 64'(bad_ready), 64'(0));
   endtask

   task automatic run_op(input vec_t v, output int acc_cyc);
      int lat;
      accept(v.a, v.b, v.cin, v.sub, acc_cyc);
      wait_result(lat);
      chk({v.name, "_latency"}, 64'(lat), 64'(NIB));
      chk({v.name, "_sum"}, 64'(bus.sum), 64'(v.exp_sum));
      chk({v.name, "_cout"}, 64'(bus.cout), 64'(v.exp_cout));
      tick();
      chk({v.name, "_ret_idle"}, {62'd0, bus.in_ready, bus.out_valid}, 64'b10);
   endtask

   initial begin
      vec_t           vecs[$];
      vec_t           v;
      int             acc;
      int             prev_acc;
      int             lat;
      int             seen;
      logic [WIDTH-1:0] held;
      logic [WIDTH:0]   r;

      vecs.push_back('{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, "add_basic"});
      vecs.push_back('{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, "add_ripple"});
      vecs.push_back('{16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, "add_cin"});
      vecs.push_back('{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, "add_max"});
      vecs.push_back('{16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, "add_mid"});
`ifdef NSA_SUB_EN
      vecs.push_back('{16'h1000, 16'h0001, 1'b1, 1'b1, 16'h0FFF, 1'b1, "sub_noborrow"});
      vecs.push_back('{16'h0000, 16'h0001, 1'b1, 1'b1, 16'hFFFF, 1'b0, "sub_borrow"});
`endif

      bus.in_valid  = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.cin       = 1'b0;
`ifdef NSA_SUB_EN
      bus.sub       = 1'b0;
`endif
      bus.out_ready = 1'b1;

      repeat (2) @(posedge clk);
      #1;
      chk("reset_outputs", {43'd0, bus.in_ready, bus.out_valid, bus.busy, bus.cout, bus.sum},
          {43'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000});
      rst = 1'b0;
      tick();

      for (int i = 0; i < vecs.size(); i++) run_op(vecs[i], acc);

      // Backpressure with a competing in_valid during DONE.
      bus.out_ready = 1'b0;
      accept(16'h2222, 16'h1111, 1'b0, 1'b0, acc);
      wait_result(lat);
      chk("bp_latency", 64'(lat), 64'(NIB));
      held = bus.sum;
      chk("bp_sum", 64'(held), 64'h3333);
      bus.a = 16'hAAAA;
      bus.b = 16'h5555;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("bp_hold", {45'd0, bus.out_valid, bus.in_ready, bus.sum}, {45'd0, 1'b1, 1'b0, held});
      end
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b0;
      tick();
      chk("bp_release", {45'd0, bus.out_valid, bus.in_ready, bus.sum}, {45'd0, 1'b0, 1'b1, held});

      // Reset after two RUN cycles discards the operation.
      accept(16'h0F00, 16'h0100, 1'b0, 1'b0, acc);
      tick();
      tick();
      rst = 1'b1;
      #1;
      chk("midrun_reset", {43'd0, bus.in_ready, bus.out_valid, bus.busy, bus.cout, bus.sum},
          {43'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000});
      tick();
      rst = 1'b0;
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) seen++;
      end
      chk("post_reset_quiet", 64'(seen), 64'(0));
      v = '{16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0, "after_reset"};
      run_op(v, acc);

      // Random back-to-back operations, out_ready held high.
      prev_acc = -1;
      for (int i = 0; i < 8; i++) begin
         v.a   = WIDTH'($urandom);
         v.b   = WIDTH'($urandom);
         v.cin = 1'($urandom_range(0, 1));
`ifdef NSA_SUB_EN
         v.sub = 1'($urandom_range(0, 1));
`else
         v.sub = 1'b0;
`endif
         r = model(v.a, v.b, v.cin, v.sub);
         v.exp_sum  = r[WIDTH-1:0];
         v.exp_cout = r[WIDTH];
         v.name = "rand";
         run_op(v, acc);
         if (prev_acc >= 0) chk("rand_spacing", 64'(acc - prev_acc), 64'(NIB + 2));
         prev_acc = acc;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
